// File: rtl/tx_pkt_sequencer_if.sv
// Byte stream from the TX packet sequencer to the DAC/LVDS serializer.
// The master drives data/valid and the serializer returns ready.
interface tx_pkt_sequencer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] dac_data;
   logic              dac_valid;
   logic              dac_ready;

   modport master (
      output dac_data,
      output dac_valid,
      input  dac_ready
   );

   modport slave (
      input  dac_data,
      input  dac_valid,
      output dac_ready
   );
endinterface

// File: rtl/tx_pkt_sequencer.sv
// TX packet sequencer: drains one packet from the TX FIFO into the DAC
// byte stream, and passes host FIFO reads through while idle.
module tx_pkt_sequencer #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   input  logic              host_rd_req,
   output logic              host_rd_grant,
   tx_pkt_sequencer_if.master dac,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  byte_cnt,
   output logic [7:0]        status
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      GAP,
      DONE
   } state_e;

   state_e            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [GW-1:0]     gap_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic              done_st_q;
   logic              len0_q;
   logic              abort_q;
   logic              ign_q;
   logic              undr_q;

   logic in_idle;
   logic rd_seq;
   logic last;

   assign in_idle = (state_q == IDLE);
   assign rd_seq  = (state_q == READ) & ~fifo_empty;
   assign last    = (cnt_q + LEN_W'(1)) == len_q;

   // Host reads only reach the FIFO while idle and not colliding with a start.
   assign host_rd_grant = in_idle & host_rd_req & ~start;
   assign fifo_rd_en    = host_rd_grant | rd_seq;

   assign dac.dac_data  = data_q;
   assign dac.dac_valid = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign byte_cnt      = cnt_q;
   assign status        = {3'b000, undr_q, ign_q, abort_q, len0_q, done_st_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_st_q <= 1'b0;
         len0_q    <= 1'b0;
         abort_q   <= 1'b0;
         ign_q     <= 1'b0;
         undr_q    <= 1'b0;
      end else if (!in_idle && abort) begin
         // Abort beats a same-cycle handshake: the byte is not counted.
         state_q <= IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b1;
         if (start) begin
            ign_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
         if (!in_idle && start) begin
            ign_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  done_st_q <= 1'b0;
                  abort_q   <= 1'b0;
                  ign_q     <= 1'b0;
                  undr_q    <= 1'b0;
                  if (pkt_len != '0) begin
                     len_q   <= pkt_len;
                     cnt_q   <= '0;
                     len0_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= READ;
                  end else begin
                     len0_q <= 1'b1;
                  end
               end
            end
            READ: begin
               if (fifo_empty) begin
                  undr_q <= 1'b1;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               data_q  <= fifo_data;
               valid_q <= 1'b1;
               state_q <= SEND;
            end
            SEND: begin
               if (dac.dac_ready) begin
                  cnt_q   <= cnt_q + LEN_W'(1);
                  valid_q <= 1'b0;
                  if (!last) begin
                     state_q <= READ;
                  end else if (GAP_CYCLES == 0) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     done_st_q <= 1'b1;
                  end else begin
                     gap_q   <= '0;
                     state_q <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  done_st_q <= 1'b1;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_pkt_sequencer.sv
// Bench for tx_pkt_sequencer: directed packets against a FIFO model,
// with a scoreboard monitor checking DAC bytes and done reports.
module tb_tx_pkt_sequencer;

   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam int GAP    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [LEN_W-1:0]  pkt_len;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data = '0;
   logic              fifo_rd_en;
   logic              host_rd_req;
   logic              host_rd_grant;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  byte_cnt;
   logic [7:0]        status;

   tx_pkt_sequencer_if #(.DATA_W(DATA_W)) dac_if ();

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tx_pkt_sequencer #(
      .DATA_W    (DATA_W),
      .LEN_W     (LEN_W),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk          (clk),
      .reset        (rst),
      .start        (start),
      .abort        (abort),
      .pkt_len      (pkt_len),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_rd_en   (fifo_rd_en),
      .host_rd_req  (host_rd_req),
      .host_rd_grant(host_rd_grant),
      .dac          (dac_if),
      .busy         (busy),
      .done         (done),
      .byte_cnt     (byte_cnt),
      .status       (status)
   );

   // FIFO model: read data appears the cycle after fifo_rd_en.
   logic [7:0] fifo_mem [16];
   int         wr_ptr   = 0;
   int         rd_ptr   = 0;
   int         rd_total = 0;
   logic       hold_empty;

   assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_total <= rd_total + 1;
         if (wr_ptr != rd_ptr) begin
            fifo_data <= fifo_mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
         end
      end
   end

   logic [7:0]  exp_q[$];
   logic [15:0] exp_done_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: pops an expectation whenever the DUT presents
   // a handshaken byte or a done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (dac_if.dac_valid && dac_if.dac_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_byte unexpected actual=%0h required=none",
                        dac_if.dac_data);
            end else begin
               chk("sb_byte", 32'(dac_if.dac_data), 32'(exp_q.pop_front()));
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_done unexpected actual=%0h required=none",
                        {byte_cnt, status});
            end else begin
               chk("sb_done", 32'({byte_cnt, status}),
                   32'(exp_done_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr % 16] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({fifo_rd_en, host_rd_grant, dac_if.dac_data,
                  dac_if.dac_valid, busy, done, byte_cnt, status});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int r0;
      rst              = 1'b1;
      start            = 1'b0;
      abort            = 1'b0;
      pkt_len          = '0;
      host_rd_req      = 1'b0;
      hold_empty       = 1'b0;
      dac_if.dac_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("reset_outs", all_outs(), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Two-byte packet, ready high; pkt_len changes after start.
      push(8'hA5);
      push(8'h3C);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      exp_done_q.push_back({8'd2, 8'h01});
      pkt_len = 8'd2;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      pkt_len = 8'd5;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("t1_rd_c%0d", c), 32'(fifo_rd_en),
             32'(c == 1 || c == 4));
         chk($sformatf("t1_vld_c%0d", c), 32'(dac_if.dac_valid),
             32'(c == 3 || c == 6));
         chk($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 11));
      end
      tick();
      @(negedge clk);
      chk("t1_byte_cnt", 32'(byte_cnt), 32'd2);
      chk("t1_status", 32'(status), 32'h01);
      tick();

      // Serializer back-pressure for five cycles on the first byte.
      push(8'h5A);
      exp_q.push_back(8'h5A);
      exp_done_q.push_back({8'd1, 8'h01});
      dac_if.dac_ready = 1'b0;
      pkt_len = 8'd1;
      r0      = rd_total;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_hold_data", 32'(dac_if.dac_data), 32'h5A);
         chk("t2_hold_vld", 32'(dac_if.dac_valid), 32'd1);
         chk("t2_no_rd", 32'(fifo_rd_en), 32'd0);
         tick();
      end
      dac_if.dac_ready = 1'b1;
      wait_done("t2_done_seen", 20);
      tick();
      @(negedge clk);
      chk("t2_byte_cnt", 32'(byte_cnt), 32'd1);
      chk("t2_status", 32'(status), 32'h01);
      chk("t2_reads", 32'(rd_total - r0), 32'd1);
      tick();

      // FIFO empty for three cycles on entry to READ.
      push(8'h77);
      exp_q.push_back(8'h77);
      exp_done_q.push_back({8'd1, 8'h11});
      hold_empty = 1'b1;
      pkt_len    = 8'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_rd", 32'(fifo_rd_en), 32'd0);
         chk("t3_stall_busy", 32'(busy), 32'd1);
         tick();
      end
      hold_empty = 1'b0;
      @(negedge clk);
      chk("t3_resume_rd", 32'(fifo_rd_en), 32'd1);
      wait_done("t3_done_seen", 20);
      tick();
      @(negedge clk);
      chk("t3_status", 32'(status), 32'h11);
      tick();

      // Abort after the first handshake of a four-byte packet.
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      exp_q.push_back(8'h11);
      pkt_len = 8'd4;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      abort = 1'b1;
      @(negedge clk);
      chk("t4_cnt_pre", 32'(byte_cnt), 32'd1);
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_vld", 32'(dac_if.dac_valid), 32'd0);
      chk("t4_byte_cnt", 32'(byte_cnt), 32'd1);
      chk("t4_status", 32'(status), 32'h04);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_no_done", 32'(done), 32'd0);
      end
      tick();
      wr_ptr = rd_ptr;

      // Zero-length start, then host reads in IDLE.
      pkt_len = 8'd0;
      r0      = rd_total;
      start   = 1'b1;
      @(negedge clk);
      chk("t5_no_rd", 32'(fifo_rd_en), 32'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_status", 32'(status), 32'h02);
      chk("t5_reads", 32'(rd_total - r0), 32'd0);
      tick();
      host_rd_req = 1'b1;
      @(negedge clk);
      chk("t5_host_rd", 32'(fifo_rd_en), 32'd1);
      chk("t5_host_gnt", 32'(host_rd_grant), 32'd1);
      tick();
      start = 1'b1;
      @(negedge clk);
      chk("t5_gnt_vs_start", 32'(host_rd_grant), 32'd0);
      chk("t5_rd_vs_start", 32'(fifo_rd_en), 32'd0);
      tick();
      start       = 1'b0;
      host_rd_req = 1'b0;
      tick();

      // Host request held through a packet; a second start mid-packet.
      push(8'hC3);
      push(8'h96);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h96);
      exp_done_q.push_back({8'd2, 8'h09});
      pkt_len     = 8'd2;
      host_rd_req = 1'b1;
      start       = 1'b1;
      @(negedge clk);
      chk("t6_gnt_c0", 32'(host_rd_grant), 32'd0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         start = (c == 5);
         @(negedge clk);
         chk($sformatf("t6_gnt_c%0d", c), 32'(host_rd_grant),
             32'(c == 12));
         chk($sformatf("t6_done_c%0d", c), 32'(done), 32'(c == 11));
      end
      tick();
      host_rd_req = 1'b0;
      start       = 1'b0;
      @(negedge clk);
      chk("t6_status", 32'(status), 32'h09);
      tick();
      wr_ptr = rd_ptr;

      // Reset asserted while a byte waits in SEND.
      push(8'hE1);
      dac_if.dac_ready = 1'b0;
      pkt_len = 8'd1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("t7_vld_pre", 32'(dac_if.dac_valid), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t7_reset_outs", all_outs(), 32'd0);
      tick();
      dac_if.dac_ready = 1'b1;
      tick();

      chk("sb_bytes_left", 32'(exp_q.size()), 32'd0);
      chk("sb_done_left", 32'(exp_done_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
